oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 110 +++++++++++
 tb/tb_oam_dma.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: copies a 256-byte CPU page into sprite OAM.
// Optional even-cycle alignment state enabled by OAM_DMA_ALIGN_EN.
module oam_dma (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        reg_w,
  input  logic [7:0]  reg_data,
  input  logic        cpu_cycle_odd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        mem_w,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_w,
  output logic        cpu_stall,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMMY,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] oa_q, oa_d;
  logic [7:0] od_q, od_d;
  logic       done_q, done_d;
  logic       align_go;

`ifdef OAM_DMA_ALIGN_EN
  assign align_go = cpu_cycle_odd;
`else
  logic unused_odd;
  assign unused_odd = cpu_cycle_odd;
  assign align_go   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      oa_q    <= '0;
      od_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      oa_q    <= oa_d;
      od_q    <= od_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    oa_d    = oa_q;
    od_d    = od_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (reg_w) begin
          page_d  = reg_data;
          idx_d   = '0;
          state_d = S_DUMMY;
        end
      end
      S_DUMMY: state_d = align_go ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        byte_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        oa_d  = idx_q;
        od_d  = byte_q;
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Page and index concatenate directly: page FF never wraps to 00
  assign mem_addr  = (state_q == S_READ) ? {page_q, idx_q} : 16'h0000;
  assign mem_w     = 1'b0;
  assign oam_w     = (state_q == S_WRITE);
  assign oam_addr  = oam_w ? idx_q : oa_q;
  assign oam_data  = oam_w ? byte_q : od_q;
  assign cpu_stall = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a page-keyed memory model.
// Build with OAM_DMA_ALIGN_EN to cover the alignment path.
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALN = 1;
`else
  localparam int ALN = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        reg_w = 1'b0;
  logic [7:0]  reg_data = '0;
  logic        cpu_cycle_odd = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_w;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_w;
  logic        cpu_stall;
  logic        done;

  oam_dma dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .reg_w(reg_w),
    .reg_data(reg_data),
    .cpu_cycle_odd(cpu_cycle_odd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_w(mem_w),
    .oam_addr(oam_addr),
    .oam_data(oam_data),
    .oam_w(oam_w),
    .cpu_stall(cpu_stall),
    .done(done)
  );

  always #5 CLK = ~CLK;

  // Memory: byte at {p,i} = i ^ p ^ 0x58, so page 02 gives i ^ 0x5A
  assign mem_rdata = mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h58;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0]  oam [256];
  logic [7:0]  exp_page = 8'h02;
  int          cyc = 0, n_stall = 0, n_wr = 0, n_done = 0;
  int          n_bad = 0, n_badpg = 0, st_start = 0, rd_start = 0;
  logic        stall_prev = 1'b0, rd_seen = 1'b0;
  logic [15:0] last_ra = '0;

  always @(posedge CLK) begin
    cyc++;
    if (cpu_stall) n_stall++;
    if (cpu_stall && !stall_prev) begin
      st_start = cyc;
      rd_seen  = 1'b0;
    end
    stall_prev = cpu_stall;
    if (oam_w) begin
      n_wr++;
      oam[oam_addr] = oam_data;
    end
    if (done) begin
      n_done++;
      if (cpu_stall) n_bad++;
    end
    if (mem_w) n_bad++;
    if (mem_addr != 16'h0000) begin
      last_ra = mem_addr;
      if (mem_addr[15:8] != exp_page) n_badpg++;
      if (!rd_seen) begin
        rd_seen  = 1'b1;
        rd_start = cyc;
      end
    end
  end

  task automatic start(input logic [7:0] pg);
    @(negedge CLK);
    exp_page = pg;
    reg_data = pg;
    reg_w    = 1'b1;
    @(negedge CLK);
    reg_w    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 700 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  int s0, w0, d0, pg0, errs;

  initial begin
    // Reset state, checked asynchronously before any clock edge
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_oamw", oam_w, 0);
    chk("rst_done", done, 0);
    chk("rst_oaddr", oam_addr, 0);
    chk("rst_odata", oam_data, 0);
    chk("rst_memw", mem_w, 0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic page-02 transfer on an even cycle
    s0 = n_stall; w0 = n_wr; d0 = n_done;
    start(8'h02);
    chk("t1_stall_on", cpu_stall, 1);
    wait_done("t1");
    chk("t1_stall_off", cpu_stall, 0);
    repeat (3) @(negedge CLK);
    chk("t1_writes", n_wr - w0, 256);
    chk("t1_stall_cyc", n_stall - s0, 513);
    chk("t1_done_cnt", n_done - d0, 1);
    chk("t1_rd_lat", rd_start - st_start, 1);
    chk("t1_oam0", oam[0], 8'h5A);
    chk("t1_oam100", oam[100], 8'h3E);
    chk("t1_oam255", oam[255], 8'hA5);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (oam[i] !== (i[7:0] ^ 8'h5A)) errs++;
    chk("t1_oam_all", errs, 0);
    chk("t1_badpg", n_badpg, 0);
    chk("t1_idle_maddr", mem_addr, 0);
    chk("t1_hold_oaddr", oam_addr, 8'hFF);

    // Write to $4014 during write 100 must be ignored
    s0 = n_stall; w0 = n_wr; pg0 = n_badpg;
    start(8'h02);
    for (int i = 0; i < 700 && (n_wr - w0) < 100; i++) @(negedge CLK);
    chk("t2_reached100", n_wr - w0, 100);
    reg_data = 8'h03;
    reg_w    = 1'b1;
    @(negedge CLK);
    reg_w    = 1'b0;
    wait_done("t2");
    repeat (3) @(negedge CLK);
    chk("t2_writes", n_wr - w0, 256);
    chk("t2_badpg", n_badpg - pg0, 0);
    chk("t2_stall_cyc", n_stall - s0, 513);

    // Page FF with odd parity at DUMMY
    s0 = n_stall; w0 = n_wr; d0 = n_done; pg0 = n_badpg;
    cpu_cycle_odd = 1'b1;
    start(8'hFF);
    @(negedge CLK);
    cpu_cycle_odd = 1'b0;
    wait_done("t3");
    repeat (3) @(negedge CLK);
    chk("t3_stall_cyc", n_stall - s0, 513 + ALN);
    chk("t3_rd_lat", rd_start - st_start, 1 + ALN);
    chk("t3_last_ra", last_ra, 16'hFFFF);
    chk("t3_last_oaddr", oam_addr, 8'hFF);
    chk("t3_last_odata", oam_data, 8'h58);
    chk("t3_oam0", oam[0], 8'hA7);
    chk("t3_writes", n_wr - w0, 256);
    chk("t3_done_cnt", n_done - d0, 1);
    chk("t3_badpg", n_badpg - pg0, 0);

    // Back-to-back: reg_w during the done pulse restarts
    start(8'h02);
    wait_done("t4a");
    s0 = n_stall; w0 = n_wr;
    reg_data = 8'h02;
    reg_w    = 1'b1;
    @(negedge CLK);
    reg_w    = 1'b0;
    chk("t4_restart", cpu_stall, 1);
    wait_done("t4b");
    repeat (3) @(negedge CLK);
    chk("t4_writes", n_wr - w0, 256);
    chk("t4_stall_cyc", n_stall - s0, 513);

    // Reset after 40 writes aborts the transfer
    w0 = n_wr; d0 = n_done;
    start(8'h02);
    for (int i = 0; i < 200 && (n_wr - w0) < 40; i++) @(negedge CLK);
    chk("t5_reached40", n_wr - w0, 40);
    RESET_N = 1'b0;
    #1;
    chk("t5_stall", cpu_stall, 0);
    chk("t5_oamw", oam_w, 0);
    chk("t5_maddr", mem_addr, 0);
    chk("t5_oaddr", oam_addr, 0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK);
    chk("t5_writes", n_wr - w0, 40);
    chk("t5_no_done", n_done - d0, 0);
    chk("t5_idle", cpu_stall, 0);

    chk("memw_done_bad", n_bad, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
